alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_issue_stage.sv | 118 +++++++++++
 tb/tb_alu_issue_stage.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared widths and FSM state type for the ALU issue stage.
package alu_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int OP_WIDTH  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage : alu_pkg

// File: rtl/alu_issue_stage.sv
// Issue stage for an external alu64bit: latches a command, waits one EXEC cycle
// for the ALU, then holds the registered result until it is consumed.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ALU_WIDTH-1:0] cmd_a,
  input  logic [ALU_WIDTH-1:0] cmd_b,
  input  logic [OP_WIDTH-1:0]  cmd_op,
  input  logic                 cmd_cin,
  input  logic                 cmd_use_carry,
  input  logic                 clear_carry,
  output logic [ALU_WIDTH-1:0] alu_a,
  output logic [ALU_WIDTH-1:0] alu_b,
  output logic                 alu_cin,
  output logic [OP_WIDTH-1:0]  alu_op,
  input  logic [ALU_WIDTH-1:0] alu_s,
  input  logic                 alu_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ALU_WIDTH-1:0] res_s,
  output logic                 res_cout,
  output logic                 carry_flag
);

  state_e               state_q, state_d;
  logic [ALU_WIDTH-1:0] a_q, b_q;
  logic [OP_WIDTH-1:0]  op_q;
  logic                 cin_q;
  logic [ALU_WIDTH-1:0] res_s_q;
  logic                 res_cout_q;
  logic                 carry_q;
  logic                 accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = cmd_valid ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready is gated by rst_n so it reads low for the whole reset window.
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE:    cmd_ready = 1'b1;
        HOLD: begin
          res_valid = 1'b1;
          cmd_ready = res_ready;
        end
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  assign accept = cmd_valid && cmd_ready;

  // carry_q here is the value before any same-edge clear, so a use_carry
  // command accepted alongside clear_carry still sees the old flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
    end else if (accept) begin
      a_q   <= cmd_a;
      b_q   <= cmd_b;
      op_q  <= cmd_op;
      cin_q <= cmd_use_carry ? carry_q : cmd_cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_s_q    <= '0;
      res_cout_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_s_q    <= alu_s;
      res_cout_q <= alu_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (clear_carry) begin
      carry_q <= 1'b0;
    end else if (state_q == EXEC) begin
      carry_q <= alu_cout;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign alu_cin    = cin_q;
  assign res_s      = res_s_q;
  assign res_cout   = res_cout_q;
  assign carry_flag = carry_q;

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural alu64bit sibling and a result scoreboard.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [63:0] cmd_a, cmd_b;
  logic [1:0]  cmd_op;
  logic        cmd_cin, cmd_use_carry, clear_carry;
  logic [63:0] alu_a, alu_b, alu_s;
  logic        alu_cin, alu_cout;
  logic [1:0]  alu_op;
  logic        res_valid, res_ready;
  logic [63:0] res_s;
  logic        res_cout, carry_flag;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cmd_cin(cmd_cin), .cmd_use_carry(cmd_use_carry), .clear_carry(clear_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_s(alu_s), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_cout(res_cout), .carry_flag(carry_flag)
  );

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
  } res_t;

  // op 0 add, 1 subtract (a + ~b + cin), 2 and, 3 or
  function automatic res_t ref_alu(input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] op, input logic cin);
    res_t        r;
    logic [64:0] w;
    w = '0;
    case (op)
      2'd0:    w = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      2'd1:    w = {1'b0, a} + {1'b0, ~b} + {64'd0, cin};
      2'd2:    w = {1'b0, a & b};
      default: w = {1'b0, a | b};
    endcase
    r.s    = w[63:0];
    r.cout = w[64];
    return r;
  endfunction

  res_t alu_model;
  always_comb begin
    alu_model = ref_alu(alu_a, alu_b, alu_op, alu_cin);
    alu_s     = alu_model.s;
    alu_cout  = alu_model.cout;
  end

  typedef struct {
    logic [63:0] a, b;
    logic [1:0]  op;
    logic        cin, use_c;
    logic [63:0] exp_s;
    logic        exp_cout, exp_cin;
  } vec_t;

  vec_t vecs[8];
  res_t sb[$];
  res_t sb_head;
  int   pass_cnt = 0, total_cnt = 0;
  int   cyc = 0, hs_cnt = 0;
  int   hs_cyc[$];
  logic cf_model;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk1("unexpected_result", 1'b1, 1'b0);
      end else begin
        sb_head = sb.pop_front();
        chk64("res_s", res_s, sb_head.s);
        chk1("res_cout", res_cout, sb_head.cout);
        $display("result  s=%h cout=%b cyc=%0d", res_s, res_cout, cyc);
      end
      hs_cnt++;
      hs_cyc.push_back(cyc);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk1("cmd_ready_timeout", cmd_ready, 1'b1);
  endtask

  // Returns one tick after the accepting edge, with the DUT in EXEC.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                       input logic cin, input logic use_c, input logic [63:0] exp_s,
                       input logic exp_cout, input logic exp_cin);
    res_t e;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_cin = cin; cmd_use_carry = use_c;
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.s = exp_s; e.cout = exp_cout;
    sb.push_back(e);
    $display("issue   a=%h b=%h op=%0d cin=%b use_c=%b", a, b, op, cin, use_c);
    chk64("alu_a", alu_a, a);
    chk64("alu_b", alu_b, b);
    chk64("alu_op", {62'd0, alu_op}, {62'd0, op});
    chk1("alu_cin", alu_cin, exp_cin);
    chk1("exec_res_valid", res_valid, 1'b0);
  endtask

  task automatic finish_one(input logic exp_cout);
    @(posedge clk); #1;
    chk1("res_valid_latency", res_valid, 1'b1);
    @(posedge clk); #1;
    chk1("carry_flag", carry_flag, exp_cout);
    chk1("idle_res_valid", res_valid, 1'b0);
    chk1("idle_cmd_ready", cmd_ready, 1'b1);
    cf_model = exp_cout;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h5, 64'h3, 2'd0, 1'b0, 1'b0, 64'h8, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
    vecs[2] = '{64'h0, 64'h0, 2'd0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b1};
    vecs[3] = '{64'h5, 64'h3, 2'd1, 1'b1, 1'b0, 64'h2, 1'b1, 1'b1};
    vecs[4] = '{64'hF0F0, 64'h0FF0, 2'd2, 1'b0, 1'b0, 64'h00F0, 1'b0, 1'b0};
    vecs[5] = '{64'hF0F0, 64'h0FF0, 2'd3, 1'b1, 1'b1, 64'hFFF0, 1'b0, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd0, 1'b1, 1'b0,
                64'h1, 1'b1, 1'b1};
    vecs[7] = '{64'h0, 64'h0, 2'd1, 1'b0, 1'b1, 64'h0, 1'b1, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    cmd_cin = 1'b0; cmd_use_carry = 1'b0; clear_carry = 1'b0; res_ready = 1'b1;
    cf_model = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk64("rst_res_s", res_s, 64'h0);
    chk1("rst_carry", carry_flag, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].use_c,
            vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_cin);
      finish_one(vecs[i].exp_cout);
    end

    // Backpressure: five cycles of stalled HOLD, then a single release.
    res_ready = 1'b0;
    issue(64'h10, 64'h20, 2'd0, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_res_valid", res_valid, 1'b1);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
      chk64("bp_res_s", res_s, 64'h30);
      chk1("bp_res_cout", res_cout, 1'b0);
      @(posedge clk); #1;
    end
    begin
      int h0;
      h0 = hs_cnt;
      res_ready = 1'b1;
      #1;
      chk1("bp_release_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk); #1;
      chki("bp_one_handshake", hs_cnt, h0 + 1);
      chk1("bp_idle_res_valid", res_valid, 1'b0);
      chk1("bp_idle_cmd_ready", cmd_ready, 1'b1);
      cf_model = 1'b0;
    end

    // Back-to-back: six commands offered continuously.
    begin
      int   sent, n, h0;
      logic acc;
      res_t e;
      sent = 0; n = 0; h0 = hs_cnt;
      hs_cyc.delete();
      while (sent < 6 && n < 60) begin
        cmd_a = {$urandom, $urandom};
        cmd_b = {$urandom, $urandom};
        cmd_op = 2'(sent % 4);
        cmd_cin = sent[0];
        cmd_use_carry = 1'b0;
        cmd_valid = 1'b1;
        #1;
        acc = cmd_ready;
        @(posedge clk);
        if (acc) begin
          e = ref_alu(cmd_a, cmd_b, cmd_op, cmd_cin);
          sb.push_back(e);
          cf_model = e.cout;
          $display("issue   a=%h b=%h op=%0d cin=%b use_c=0", cmd_a, cmd_b, cmd_op, cmd_cin);
          sent++;
        end
        #1;
        n++;
      end
      cmd_valid = 1'b0;
      n = 0;
      while (hs_cnt < h0 + 6 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chki("b2b_results", hs_cnt - h0, 6);
      for (int i = 1; i < hs_cyc.size(); i++)
        chki("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
      @(posedge clk); #1;
      chk1("b2b_carry", carry_flag, cf_model);
    end

    // clear_carry coinciding with the EXEC capture of a carry-out.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    clear_carry = 1'b1;
    @(posedge clk); #1;
    clear_carry = 1'b0;
    chk1("clr_exec_carry", carry_flag, 1'b0);
    chk1("clr_exec_res_cout", res_cout, 1'b1);
    chk1("clr_exec_res_valid", res_valid, 1'b1);
    @(posedge clk); #1;
    cf_model = 1'b0;

    // clear_carry coinciding with a use_carry acceptance uses the old flag.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    finish_one(1'b1);
    clear_carry = 1'b1;
    issue(64'h0, 64'h0, 2'd0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b1);
    clear_carry = 1'b0;
    chk1("clr_accept_carry", carry_flag, 1'b0);
    finish_one(1'b0);

    // Reset pulse while in EXEC discards the in-flight result.
    issue(64'h7, 64'h9, 2'd0, 1'b0, 1'b0, 64'h10, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk1("mid_rst_res_valid", res_valid, 1'b0);
    chk1("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk64("mid_rst_alu_a", alu_a, 64'h0);
    chk64("mid_rst_res_s", res_s, 64'h0);
    chk1("mid_rst_res_cout", res_cout, 1'b0);
    chk1("mid_rst_carry", carry_flag, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1("post_mid_rst_res_valid", res_valid, 1'b0);
    end
    chk1("post_mid_rst_cmd_ready", cmd_ready, 1'b1);
    issue(64'h100, 64'h1, 2'd0, 1'b0, 1'b0, 64'h101, 1'b0, 1'b0);
    finish_one(1'b0);

    chki("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_alu_issue_stage
